// File: rtl/pushbutton_conditioner.sv
// -----------------------------------------------------------------------------
// pushbutton_conditioner
//
// Four-channel front end for the board's raw active-low pushbuttons. Each
// channel is synchronised (two flops), debounced by a counter plus a small
// state machine, and presented as a clean active-low level to the Nios
// pushbutton PIO. Press/release pulses and sticky press flags with an
// interrupt request let software poll or take an interrupt.
//
// Optional feature: define PUSHBUTTON_AUTOREPEAT_EN to generate auto-repeat
// press pulses while a key is held (REPEAT_DELAY, then every REPEAT_PERIOD).
// Without it the repeat parameters are unused and each accepted press gives
// exactly one press pulse.
//
// Parameters:
//   DB_CYCLES     consecutive stable samples needed to accept a change (>= 2)
//   REPEAT_DELAY  hold time before the first auto-repeat pulse
//   REPEAT_PERIOD interval between later auto-repeat pulses
//   CNT_W         counter width, holds max of the three values above
//
// Ports:
//   clk_clk            in   system clock
//   reset_reset        in   asynchronous active-high reset
//   key_n_i[3:0]       in   raw keys, active-low, asynchronous to clk_clk
//   pushbutton_export  out  debounced level, active-low (to PIO)
//   press_pulse_o      out  one-cycle pulse per accepted press / repeat
//   release_pulse_o    out  one-cycle pulse per accepted release
//   press_flag_o       out  sticky press flags
//   flag_clr_i         in   write-one-to-clear for press_flag_o
//   irq_o              out  OR of press_flag_o
// -----------------------------------------------------------------------------
module pushbutton_conditioner #(
   parameter int DB_CYCLES     = 1_000_000,
   parameter int REPEAT_DELAY  = 25_000_000,
   parameter int REPEAT_PERIOD = 5_000_000,
   parameter int CNT_W         = 25
) (
   input  logic       clk_clk,
   input  logic       reset_reset,
   input  logic [3:0] key_n_i,
   output logic [3:0] pushbutton_export,
   output logic [3:0] press_pulse_o,
   output logic [3:0] release_pulse_o,
   output logic [3:0] press_flag_o,
   input  logic [3:0] flag_clr_i,
   output logic       irq_o
);

   typedef enum logic [1:0] {
      ST_RELEASED     = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_PRESSED      = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } state_t;

   // Counters compare against the last count value so they never need to
   // reach the parameter itself and can never wrap.
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

   // Synchroniser
   logic [3:0] s1_q, s1_d;
   logic [3:0] s2_q, s2_d;

   // Per-channel debounce FSM and counter
   state_t           state_q [4];
   state_t           state_d [4];
   logic [CNT_W-1:0] cnt_q   [4];
   logic [CNT_W-1:0] cnt_d   [4];

   // Registered outputs
   logic [3:0] export_q,  export_d;
   logic [3:0] press_q,   press_d;
   logic [3:0] release_q, release_d;
   logic [3:0] flag_q,    flag_d;

`ifdef PUSHBUTTON_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] RPT_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RPT_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

   // rpt_arm marks that the initial delay has elapsed and the shorter
   // period now applies.
   logic [CNT_W-1:0] rpt_cnt_q [4];
   logic [CNT_W-1:0] rpt_cnt_d [4];
   logic [3:0]       rpt_arm_q, rpt_arm_d;
`else
   logic unused_repeat_cfg;
   assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      s1_d      = key_n_i;
      s2_d      = s1_q;
      export_d  = export_q;
      press_d   = 4'h0;
      release_d = 4'h0;
`ifdef PUSHBUTTON_AUTOREPEAT_EN
      rpt_arm_d = 4'h0;
`endif

      for (int i = 0; i < 4; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
`ifdef PUSHBUTTON_AUTOREPEAT_EN
         // The repeat timer only survives while the channel stays in PRESSED,
         // so every other path (including a bounce back from RELEASE_WAIT)
         // restarts it from zero with the initial delay.
         rpt_cnt_d[i] = '0;
`endif

         case (state_q[i])
            ST_RELEASED: begin
               if (!s2_q[i]) begin
                  state_d[i] = ST_PRESS_WAIT;
                  cnt_d[i]   = CNT_W'(1);
               end else begin
                  cnt_d[i]   = '0;
               end
            end

            ST_PRESS_WAIT: begin
               if (s2_q[i]) begin
                  state_d[i] = ST_RELEASED;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == DB_LAST) begin
                  state_d[i]  = ST_PRESSED;
                  export_d[i] = 1'b0;
                  press_d[i]  = 1'b1;
                  cnt_d[i]    = '0;
               end else begin
                  cnt_d[i]    = cnt_q[i] + CNT_W'(1);
               end
            end

            ST_PRESSED: begin
               if (s2_q[i]) begin
                  state_d[i] = ST_RELEASE_WAIT;
                  cnt_d[i]   = CNT_W'(1);
               end else begin
                  cnt_d[i]   = '0;
`ifdef PUSHBUTTON_AUTOREPEAT_EN
                  rpt_arm_d[i] = rpt_arm_q[i];
                  if (rpt_cnt_q[i] == (rpt_arm_q[i] ? RPT_PERIOD_LAST : RPT_DELAY_LAST)) begin
                     press_d[i]   = 1'b1;
                     rpt_arm_d[i] = 1'b1;
                     rpt_cnt_d[i] = '0;
                  end else begin
                     rpt_cnt_d[i] = rpt_cnt_q[i] + CNT_W'(1);
                  end
`endif
               end
            end

            ST_RELEASE_WAIT: begin
               if (!s2_q[i]) begin
                  state_d[i] = ST_PRESSED;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == DB_LAST) begin
                  state_d[i]   = ST_RELEASED;
                  export_d[i]  = 1'b1;
                  release_d[i] = 1'b1;
                  cnt_d[i]     = '0;
               end else begin
                  cnt_d[i]     = cnt_q[i] + CNT_W'(1);
               end
            end

            default: begin
               state_d[i] = ST_RELEASED;
               cnt_d[i]   = '0;
            end
         endcase
      end

      // Flags follow the registered pulse, so they rise one cycle after it.
      // OR-ing the set term last makes a simultaneous set win over a clear.
      flag_d = (flag_q & ~flag_clr_i) | press_q;
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         s1_q      <= 4'hF;
         s2_q      <= 4'hF;
         export_q  <= 4'hF;
         press_q   <= 4'h0;
         release_q <= 4'h0;
         flag_q    <= 4'h0;
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= ST_RELEASED;
            cnt_q[i]   <= '0;
         end
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         export_q  <= export_d;
         press_q   <= press_d;
         release_q <= release_d;
         flag_q    <= flag_d;
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

`ifdef PUSHBUTTON_AUTOREPEAT_EN
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         rpt_arm_q <= 4'h0;
         for (int i = 0; i < 4; i++) begin
            rpt_cnt_q[i] <= '0;
         end
      end else begin
         rpt_arm_q <= rpt_arm_d;
         for (int i = 0; i < 4; i++) begin
            rpt_cnt_q[i] <= rpt_cnt_d[i];
         end
      end
   end
`endif

   assign pushbutton_export = export_q;
   assign press_pulse_o     = press_q;
   assign release_pulse_o   = release_q;
   assign press_flag_o      = flag_q;
   assign irq_o             = |flag_q;

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// -----------------------------------------------------------------------------
// Testbench for pushbutton_conditioner (DB_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3). Stimulus pushes expected pulse events into a queue; a
// separate monitor pops and compares whenever a pulse appears.
// -----------------------------------------------------------------------------
module tb_pushbutton_conditioner;

   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] key_n;
   logic [3:0] clr;
   logic [3:0] pb_export;
   logic [3:0] press;
   logic [3:0] release_p;
   logic [3:0] flag;
   logic       irq;

   pushbutton_conditioner #(
      .DB_CYCLES     (DB),
      .REPEAT_DELAY  (RD),
      .REPEAT_PERIOD (RP),
      .CNT_W         (8)
   ) dut (
      .clk_clk           (clk),
      .reset_reset       (rst),
      .key_n_i           (key_n),
      .pushbutton_export (pb_export),
      .press_pulse_o     (press),
      .release_pulse_o   (release_p),
      .press_flag_o      (flag),
      .flag_clr_i        (clr),
      .irq_o             (irq)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         c;
      logic [3:0] pr;
      logic [3:0] rl;
      logic [3:0] ex;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_e;
   int  n_chk  = 0;
   int  n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  nm, act, act, exp, exp, cyc);
      end
   endtask

   // Expected events for keys in 'mask' going low at cycle cd and high at cu.
   // The FSM sees a key change three edges later and accepts it after
   // DB_CYCLES samples, i.e. DB+2 edges after the change.
   function automatic void push_hold(input logic [3:0] mask, input int cd, input int cu);
      ev_t e;
      int  p;
      p    = cd + DB + 2;
      e.c  = p;
      e.pr = mask;
      e.rl = 4'h0;
      e.ex = ~mask;
      exp_q.push_back(e);
`ifdef PUSHBUTTON_AUTOREPEAT_EN
      // Repeats fire while PRESSED still sees the key low (edges < cu+3).
      for (int r = p + RD; r < cu + 3; r += RP) begin
         e.c = r;
         exp_q.push_back(e);
      end
`endif
      e.c  = cu + DB + 2;
      e.pr = 4'h0;
      e.rl = mask;
      e.ex = 4'hF;
      exp_q.push_back(e);
   endfunction

   task automatic key_event(input logic [3:0] mask, input int hold);
      int cd;
      cd = cyc;
      key_n = key_n & ~mask;
      push_hold(mask, cd, cd + hold);
      repeat (hold) @(negedge clk);
      key_n = key_n | mask;
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 80) begin
         @(negedge clk);
         n++;
      end
      chk(nm, exp_q.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   // Monitor: every pulse must match the next expected event exactly.
   always @(negedge clk) begin
      if (!rst && ((press | release_p) != 4'h0)) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_pulse: press=%b release=%b at cycle %0d, none expected",
                     press, release_p, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            chk("event_cycle",   cyc,       mon_e.c);
            chk("press_bits",    press,     mon_e.pr);
            chk("release_bits",  release_p, mon_e.rl);
            chk("export_level",  pb_export, mon_e.ex);
         end
      end
   end

   initial begin
      int cd;
      rst   = 1'b1;
      key_n = 4'hF;
      clr   = 4'h0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_export", pb_export, 4'hF);
      chk("rst_press",  press,     4'h0);
      chk("rst_flag",   flag,      4'h0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_export",  pb_export, 4'hF);
      chk("idle_release", release_p, 4'h0);
      chk("idle_irq",     irq,       1'b0);

      // Key 0 held 20 cycles; flag and irq rise one cycle after the pulse
      cd = cyc;
      key_n[0] = 1'b0;
      push_hold(4'b0001, cd, cd + 20);
      repeat (DB + 2) @(negedge clk);
      chk("flag0_at_pulse", flag[0], 1'b0);
      chk("irq_at_pulse",   irq,     1'b0);
      @(negedge clk);
      chk("flag0_after_pulse", flag[0], 1'b1);
      chk("irq_after_pulse",   irq,     1'b1);
      repeat (20 - DB - 3) @(negedge clk);
      key_n[0] = 1'b1;
      drain("drain_key0");

      // Key 1 bounce: 3 low / 1 high five times, then a real press
      for (int k = 0; k < 5; k++) begin
         key_n[1] = 1'b0;
         repeat (3) @(negedge clk);
         key_n[1] = 1'b1;
         @(negedge clk);
      end
      chk("bounce_export", pb_export, 4'hF);
      key_event(4'b0010, 10);
      drain("drain_bounce");

      // Flags latched, then clear them all
      chk("flags_latched", flag, 4'b0011);
      clr = 4'hF;
      @(negedge clk);
      clr = 4'h0;
      chk("flags_cleared", flag, 4'h0);
      chk("irq_cleared",   irq,  1'b0);

      // Clear in the same cycle as a press pulse: set wins
      cd = cyc;
      key_n[0] = 1'b0;
      push_hold(4'b0001, cd, cd + 8);
      repeat (DB + 2) @(negedge clk);
      clr[0] = 1'b1;
      @(negedge clk);
      chk("set_wins_flag0", flag[0], 1'b1);
      @(negedge clk);
      clr[0]   = 1'b0;
      key_n[0] = 1'b1;
      chk("clear_flag0", flag[0], 1'b0);
      chk("clear_irq",   irq,     1'b0);
      drain("drain_setwins");

      // Keys 2 and 3 together: simultaneous press and release events
      key_event(4'b1100, 8);
      drain("drain_simul");
      chk("simul_flags", flag, 4'b1100);

      // Key 0 held 30 cycles after acceptance (repeats only when enabled)
      key_event(4'b0001, 36);
      drain("drain_long");
      chk("final_export", pb_export, 4'hF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pushbutton_conditioner.md
# pushbutton_conditioner

Four-channel pushbutton front end between the board's raw active-low keys and the Nios pushbutton PIO input (`pushbutton_external_connection_export[3:0]`). Each channel synchronises its key, debounces it with a per-channel counter and state machine, and presents a clean active-low level to the PIO. It also generates press and release pulses and sticky press flags with an interrupt request, so software can poll or take an interrupt instead of sampling bouncy keys.

## Interface
- `DB_CYCLES`, 1_000_000: consecutive stable samples required to accept a level change (20 ms at 50 MHz); must be ≥ 2.
- `REPEAT_DELAY`, 25_000_000: hold time before the first auto-repeat pulse. Used only with auto-repeat.
- `REPEAT_PERIOD`, 5_000_000: interval between subsequent auto-repeat pulses. Used only with auto-repeat.
- `CNT_W`, 25: counter width; must hold max(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).
- `clk_clk`  in  1  system clock, 50 MHz.
- `reset_reset`  in  1  asynchronous, active-high reset.
- `key_n_i`  in  4  raw keys, active-low, asynchronous to `clk_clk`.
- `pushbutton_export`  out  4  debounced level, active-low; drives the PIO.
- `press_pulse_o`  out  4  one-cycle pulse per accepted press, or per auto-repeat when enabled.
- `release_pulse_o`  out  4  one-cycle pulse per accepted release.
- `press_flag_o`  out  4  sticky press flags.
- `flag_clr_i`  in  4  write-one-to-clear for `press_flag_o`, one cycle per request.
- `irq_o`  out  1  OR of `press_flag_o`.

## Operation
- Synchroniser:
  - Two flops per channel; both reset to 1.
  - The FSM sees `sync = s2`.
- Per-channel FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT. Reset state is RELEASED.
- RELEASED:
  - `sync == 0`: go to PRESS_WAIT, cnt = 1.
  - Otherwise: cnt = 0.
- PRESS_WAIT:
  - `sync == 1` (bounce): return to RELEASED, cnt = 0, no pulse.
  - `sync == 0` and cnt == DB_CYCLES−1: go to PRESSED, export bit = 0, press pulse, cnt = 0.
  - Otherwise: cnt + 1.
- PRESSED:
  - `sync == 1`: go to RELEASE_WAIT, cnt = 1.
  - Auto-repeat, if compiled in: runs in this state only.
- RELEASE_WAIT:
  - `sync == 0`: return to PRESSED, no pulse; the repeat timer restarts.
  - DB_CYCLES consecutive `sync == 1` samples: go to RELEASED, export bit = 1, release pulse.
- Flags:
  - `press_flag_o[i]` sets on `press_pulse_o[i]`.
  - Clears on `flag_clr_i[i]`.
  - Set and clear in the same cycle: set wins.
- Channels are fully independent. Simultaneous events on several channels are all reported in the same cycle.
- Reset values:
  - `pushbutton_export` = 4'hF.
  - Pulses = 0, flags = 0, `irq_o` = 0.
  - Counters = 0, all FSMs in RELEASED.
- Reset assertion mid-debounce or mid-hold abandons the event; no pulse is emitted.

## Timing
- Accepted-change latency from the raw edge is DB_CYCLES+2 cycles, with +1 cycle of asynchronous sampling uncertainty.
- `pushbutton_export`, `press_pulse_o` and `release_pulse_o` update on the same clock edge; all are registered.
- `press_flag_o` and `irq_o` assert one cycle after the press pulse. A clear takes effect on the next edge.
- Glitches shorter than DB_CYCLES samples never change any output.
- Counters never wrap. They are compared against parameter−1 and cleared on every transition.

## Configuration
- `PUSHBUTTON_AUTOREPEAT_EN` defined:
  - In PRESSED, a repeat counter runs.
  - First extra `press_pulse_o` fires REPEAT_DELAY cycles after the accepted press.
  - Further pulses follow every REPEAT_PERIOD cycles until leaving PRESSED.
  - Repeat pulses also set the flag.
- `PUSHBUTTON_AUTOREPEAT_EN` undefined:
  - Repeat logic and parameters are unused.
  - Exactly one press pulse per accepted press.

## Test plan
Bench parameters: DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Reset, keys high -> export 4'hF; pulses, flags and `irq_o` all 0.
- `key_n_i[0]` low held 20 cycles -> export 4'hE at cycle 6 (±1); one `press_pulse_o[0]`; flag[0]=1 and `irq_o`=1 one cycle later.
- `key_n_i[1]` toggled low 3 cycles / high 1 cycle, five times, then low -> no pulse during the bounce; export[1] falls exactly DB_CYCLES+2 cycles after the final low edge.
- `flag_clr_i[0]` pulsed in the same cycle as a new `press_pulse_o[0]` -> flag stays 1; a clear one cycle later -> flag 0, `irq_o` 0.
- Keys 2 and 3 pressed in the same cycle -> both export bits fall and both press pulses fire on the same edge; releasing them gives simultaneous release pulses.
- With `PUSHBUTTON_AUTOREPEAT_EN`, key 0 held 30 cycles after acceptance -> press pulses at +0, +10, +13, +16, +19, …; no repeat pulse after release is accepted.
